decade_2421_stopwatch_ctrl: RTL and testbench

Sequencing controller for a chain of 2421-coded decade digits. It owns a run/pause/idle state machine, a clock prescaler and the ripple carry between digits, and a lap register, so that the lab board's push-buttons drive a multi-digit 2421 stopwatch. It sits between the debounced button inputs and the 7-segment/LED display logic. Its digit update rule matches our single-digit 2421 decade counter.

---
 rtl/decade_2421_stopwatch_ctrl_if.sv | 25 ++
 rtl/decade_2421_stopwatch_ctrl.sv | 159 +++++++++++++++
 tb/tb_decade_2421_stopwatch_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/decade_2421_stopwatch_ctrl_if.sv
// Button inputs and display-side outputs of the 2421 stopwatch controller.
interface decade_2421_stopwatch_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start_stop;
  logic                  clear;
  logic                  lap;
  logic [4*DIGITS-1:0]   out;
  logic [4*DIGITS-1:0]   lap_out;
  logic                  running;
  logic                  tick;
  logic                  overflow;

  // Button/debounce side drives the inputs.
  modport master (
    output start_stop, clear, lap,
    input  out, lap_out, running, tick, overflow
  );

  // Controller side.
  modport slave (
    input  start_stop, clear, lap,
    output out, lap_out, running, tick, overflow
  );
endinterface

// File: rtl/decade_2421_stopwatch_ctrl.sv
// Multi-digit 2421 stopwatch sequencer: run/pause/idle FSM, prescaler,
// single-cycle carry across digits, lap capture and sticky overflow.
//
// state | meaning
// IDLE  | stopped and zeroed, prescaler held at 0
// RUN   | prescaler counting, count advances on each tick
// PAUSE | count and prescaler frozen, clear returns to IDLE
module decade_2421_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  decade_2421_stopwatch_ctrl_if.slave        bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ss_prev_q, clr_prev_q, lap_prev_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   lap_q, lap_d;
  logic            ovf_q, ovf_d;

  logic            ss_edge, clr_edge, lap_edge;
  logic            tick;
  logic [DIGITS:0] step_en;
  logic [CW-1:0]   count_step;

  // 2421 successor; invalid codes collapse to zero.
  function automatic logic [3:0] step_2421(input logic [3:0] d);
    logic [3:0] n;
    case (d)
      4'b0000: n = 4'b0001;
      4'b0001: n = 4'b0010;
      4'b0010: n = 4'b0011;
      4'b0011: n = 4'b0100;
      4'b0100: n = 4'b1011;
      4'b1011: n = 4'b1100;
      4'b1100: n = 4'b1101;
      4'b1101: n = 4'b1110;
      4'b1110: n = 4'b1111;
      default: n = 4'b0000;
    endcase
    return n;
  endfunction

  assign ss_edge  = bus.start_stop & ~ss_prev_q;
  assign clr_edge = bus.clear      & ~clr_prev_q;
  assign lap_edge = bus.lap        & ~lap_prev_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; clear beats start_stop in PAUSE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_edge) state_d = RUN;
      RUN:     if (ss_edge) state_d = PAUSE;
      PAUSE: begin
        if (clr_edge)     state_d = IDLE;
        else if (ss_edge) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state only.
  always_comb begin
    bus.running = (state_q == RUN);
    tick        = (state_q == RUN) && (presc_q == PW'(PRESCALE - 1));
    bus.tick    = tick;
  end

  // Carry enables resolved combinationally across all digits.
  always_comb begin
    step_en    = '0;
    count_step = count_q;
    step_en[0] = tick;
    for (int i = 0; i < DIGITS; i++) begin
      step_en[i+1] = step_en[i] & (count_q[4*i +: 4] == 4'b1111);
      if (step_en[i]) count_step[4*i +: 4] = step_2421(count_q[4*i +: 4]);
    end
  end

  // Datapath next values for prescaler, count, lap register and overflow.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (clr_edge) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (lap_edge) lap_d = count_q;
        if (tick) begin
          presc_d = '0;
          count_d = count_step;
          if (step_en[DIGITS]) ovf_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (clr_edge) begin
          presc_d = '0;
          count_d = '0;
          lap_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: presc_d = '0;
    endcase
  end

  // Datapath and edge-detect registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
      lap_prev_q <= 1'b0;
      presc_q    <= '0;
      count_q    <= '0;
      lap_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ss_prev_q  <= bus.start_stop;
      clr_prev_q <= bus.clear;
      lap_prev_q <= bus.lap;
      presc_q    <= presc_d;
      count_q    <= count_d;
      lap_q      <= lap_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.out      = count_q;
  assign bus.lap_out  = lap_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_decade_2421_stopwatch_ctrl.sv
// Stopwatch controller bench: directed test-plan sequences followed by random
// button activity, all checked against a decimal-valued reference model.
module tb_decade_2421_stopwatch_ctrl;
  localparam int DIGITS   = 2;
  localparam int PRESCALE = 2;
  localparam int CW       = 4 * DIGITS;
  localparam int MAXV     = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decade_2421_stopwatch_ctrl_if #(.DIGITS(DIGITS)) bus ();

  decade_2421_stopwatch_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: count kept as a plain decimal number.
  int m_val, m_lap, m_phase, m_mode;
  bit m_ovf, p_ss, p_clr, p_lap;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  function automatic logic [CW-1:0] enc(input int v);
    logic [3:0] tbl [10];
    logic [CW-1:0] r;
    int x;
    tbl = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = tbl[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ss_e, clr_e, lap_e, tk;
    ss_e  = bus.start_stop & ~p_ss;
    clr_e = bus.clear & ~p_clr;
    lap_e = bus.lap & ~p_lap;
    if (!rst) begin
      m_val = 0; m_lap = 0; m_phase = 0; m_mode = M_IDLE; m_ovf = 0;
      p_ss = 0; p_clr = 0; p_lap = 0;
      return;
    end
    tk = (m_mode == M_RUN) && (m_phase == PRESCALE - 1);
    case (m_mode)
      M_IDLE: begin
        m_phase = 0;
        if (clr_e) begin m_val = 0; m_ovf = 0; end
        if (ss_e) m_mode = M_RUN;
      end
      M_RUN: begin
        if (lap_e) m_lap = m_val;
        if (tk) begin
          m_phase = 0;
          if (m_val == MAXV - 1) m_ovf = 1;
          m_val = (m_val + 1) % MAXV;
        end else begin
          m_phase++;
        end
        if (ss_e) m_mode = M_PAUSE;
      end
      default: begin
        if (clr_e) begin
          m_mode = M_IDLE; m_val = 0; m_lap = 0; m_ovf = 0; m_phase = 0;
        end else if (ss_e) begin
          m_mode = M_RUN;
        end
      end
    endcase
    p_ss = bus.start_stop; p_clr = bus.clear; p_lap = bus.lap;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("out",      32'(bus.out),      32'(enc(m_val)));
    chk("lap_out",  32'(bus.lap_out),  32'(enc(m_lap)));
    chk("running",  32'(bus.running),  32'(m_mode == M_RUN));
    chk("tick",     32'(bus.tick),     32'((m_mode == M_RUN) && (m_phase == PRESCALE - 1)));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
    rst            = 1'b0;
    cycles(3);
    chk("reset_out", 32'(bus.out), 32'h0);
    rst = 1'b1;

    // Start and count to 10.
    bus.start_stop = 1'b1; cycle(); bus.start_stop = 1'b0;
    chk("start_running", 32'(bus.running), 32'h1);
    cycles(20);
    chk("seq_ten", 32'(bus.out), 32'h10);

    // Run to full scale, then wrap.
    cycles(178);
    chk("full_scale", 32'(bus.out), 32'hFF);
    cycles(2);
    chk("wrap_out", 32'(bus.out), 32'h00);
    chk("wrap_ovf", 32'(bus.overflow), 32'h1);
    chk("wrap_run", 32'(bus.running), 32'h1);

    // Pause then clear.
    bus.start_stop = 1'b1; cycle(); bus.start_stop = 1'b0;
    cycles(20);
    bus.clear = 1'b1; cycle(); bus.clear = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 32'h0);
    chk("clr_idle", 32'(bus.running), 32'h0);

    // Clear and start on the same edge in PAUSE.
    bus.start_stop = 1'b1; cycle(); bus.start_stop = 1'b0;
    cycles(5);
    bus.start_stop = 1'b1; cycle(); bus.start_stop = 1'b0;
    cycle();
    bus.start_stop = 1'b1; bus.clear = 1'b1; cycle();
    bus.start_stop = 1'b0; bus.clear = 1'b0;
    chk("simul_running", 32'(bus.running), 32'h0);
    chk("simul_out", 32'(bus.out), 32'h0);

    // Reset while running.
    bus.start_stop = 1'b1; cycle(); bus.start_stop = 1'b0;
    cycles(10);
    rst = 1'b0; cycle(); rst = 1'b1;
    chk("rst_mid_out", 32'(bus.out), 32'h0);
    chk("rst_mid_run", 32'(bus.running), 32'h0);

    // Lap in a tick cycle at 0x0E, then clear ignored in RUN.
    bus.start_stop = 1'b1; cycle(); bus.start_stop = 1'b0;
    cycles(17);
    chk("lap_pre_tick", 32'(bus.tick), 32'h1);
    bus.lap = 1'b1; cycle(); bus.lap = 1'b0;
    chk("lap_capture", 32'(bus.lap_out), 32'h0E);
    chk("lap_step", 32'(bus.out), 32'h0F);
    bus.clear = 1'b1; cycle(); bus.clear = 1'b0;
    chk("clr_in_run", 32'(bus.running), 32'h1);

    // Random button activity.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.start_stop = ~bus.start_stop;
      bus.clear = ($urandom_range(0, 9) == 0);
      bus.lap   = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
